load_store_unit: RTL and testbench

- Memory-stage controller sitting directly upstream of data_mem; turns MIPS lb/lbu/lh/lhu/lw/sb/sh/sw requests from the EX/MEM register into word-only memread/memwrite cycles.
- Sub-word stores use read-modify-write sequencing.
- Sub-word loads are extracted and sign- or zero-extended.
- Misaligned and out-of-range accesses are detected and flagged, and issue no memory traffic.

---
 rtl/load_store_unit.sv | 191 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store controller in front of a word-only data memory.
// Sub-word stores are done as read-modify-write; sub-word loads are lane
// extracted and sign/zero extended. Misaligned or out-of-range requests
// complete immediately with a fault flag and never touch memory.
module load_store_unit #(
    parameter logic [31:0] MEM_BYTES  = 32'h3000,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        addr_fault,
    output logic [31:0] mem_addr,
    output logic        memread,
    output logic        memwrite,
    output logic [31:0] write_d,
    input  logic [31:0] read_d
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_FLT,
        S_DONE
    } state_e;

    state_e      state_q;
    logic        is_load_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;

    logic        done_q;
    logic [31:0] load_data_q;
    logic        misalign_q;
    logic        addr_fault_q;
    logic [31:0] mem_addr_q;
    logic        memread_q;
    logic        memwrite_q;
    logic [31:0] write_d_q;

    logic        accept_c;
    logic        mis_c;
    logic        af_c;
    logic [4:0]  byte_sh_c;
    logic [4:0]  lane_sh_c;
    logic [15:0] lane_c;
    logic [31:0] lane_mask_c;
    logic [31:0] ext_c;
    logic [31:0] merged_c;

    // Request acceptance and fault detection on the live request inputs
    always_comb begin
        accept_c = reset && (state_q == S_IDLE) && req_valid && (req_load || req_store);
        mis_c    = (req_size == SZ_ILL)
                || ((req_size == SZ_HALF) && req_addr[0])
                || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        af_c     = (req_addr >= MEM_BYTES);
    end

    assign stall = accept_c || (state_q == S_RD) || (state_q == S_CAP) || (state_q == S_WR);

    // Lane position, load extension and store merge for the captured request
    always_comb begin
        byte_sh_c = 5'd0;
        case (off_q)
            2'd0:    byte_sh_c = BIG_ENDIAN ? 5'd24 : 5'd0;
            2'd1:    byte_sh_c = BIG_ENDIAN ? 5'd16 : 5'd8;
            2'd2:    byte_sh_c = BIG_ENDIAN ? 5'd8  : 5'd16;
            default: byte_sh_c = BIG_ENDIAN ? 5'd0  : 5'd24;
        endcase
        lane_sh_c   = (size_q == SZ_BYTE) ? byte_sh_c
                    : ((off_q[1] ^ BIG_ENDIAN) ? 5'd16 : 5'd0);
        lane_c      = 16'(read_d >> lane_sh_c);
        lane_mask_c = ((size_q == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_sh_c;
        merged_c    = (read_d & ~lane_mask_c) | ((wdata_q << lane_sh_c) & lane_mask_c);
        case (size_q)
            SZ_BYTE: ext_c = uns_q ? {24'd0, lane_c[7:0]} : {{24{lane_c[7]}}, lane_c[7:0]};
            SZ_HALF: ext_c = uns_q ? {16'd0, lane_c}      : {{16{lane_c[15]}}, lane_c};
            default: ext_c = read_d;
        endcase
    end

    // Sequencer with registered memory-side and completion outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            is_load_q    <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            wdata_q      <= 32'd0;
            done_q       <= 1'b0;
            load_data_q  <= 32'd0;
            misalign_q   <= 1'b0;
            addr_fault_q <= 1'b0;
            mem_addr_q   <= 32'd0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            write_d_q    <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        is_load_q <= req_load;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        off_q     <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        if (mis_c || af_c) begin
                            state_q      <= S_FLT;
                            done_q       <= 1'b1;
                            misalign_q   <= mis_c;
                            addr_fault_q <= af_c;
                            load_data_q  <= 32'd0;
                        end else begin
                            mem_addr_q <= {req_addr[31:2], 2'b00};
                            if (!req_load && (req_size == SZ_WORD)) begin
                                state_q    <= S_WR;
                                memwrite_q <= 1'b1;
                                write_d_q  <= req_wdata;
                            end else begin
                                state_q   <= S_RD;
                                memread_q <= 1'b1;
                            end
                        end
                    end
                end
                S_RD: begin
                    memread_q <= 1'b0;
                    state_q   <= S_CAP;
                end
                S_CAP: begin
                    if (is_load_q) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        load_data_q <= ext_c;
                        mem_addr_q  <= 32'd0;
                    end else begin
                        state_q    <= S_WR;
                        memwrite_q <= 1'b1;
                        write_d_q  <= merged_c;
                    end
                end
                S_WR: begin
                    memwrite_q  <= 1'b0;
                    write_d_q   <= 32'd0;
                    mem_addr_q  <= 32'd0;
                    done_q      <= 1'b1;
                    load_data_q <= 32'd0;
                    state_q     <= S_DONE;
                end
                S_FLT, S_DONE: begin
                    done_q       <= 1'b0;
                    misalign_q   <= 1'b0;
                    addr_fault_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign done       = done_q;
    assign load_data  = load_data_q;
    assign misalign   = misalign_q;
    assign addr_fault = addr_fault_q;
    assign mem_addr   = mem_addr_q;
    assign memread    = memread_q;
    assign memwrite   = memwrite_q;
    assign write_d    = write_d_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a simple word memory behind it.
module tb_load_store_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_load;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        misalign;
    logic        addr_fault;
    logic [31:0] mem_addr;
    logic        memread;
    logic        memwrite;
    logic [31:0] write_d;
    logic [31:0] read_d;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_load     (req_load),
        .req_store    (req_store),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .done         (done),
        .load_data    (load_data),
        .misalign     (misalign),
        .addr_fault   (addr_fault),
        .mem_addr     (mem_addr),
        .memread      (memread),
        .memwrite     (memwrite),
        .write_d      (write_d),
        .read_d       (read_d)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word memory: read data appears the cycle after memread
    logic [31:0] mem [0:3071];
    always @(posedge clock) begin
        if (memread)  read_d <= mem[mem_addr[13:2]];
        if (memwrite) mem[mem_addr[13:2]] <= write_d;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request in an idle cycle and follow it to completion
    task automatic run_op(input logic ld, input logic st, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd,
                          output int dcyc, output int nrd, output int nwr,
                          output logic [31:0] wdat, output logic [31:0] ldat,
                          output logic mis, output logic af, output logic stall0);
        @(negedge clock);
        req_valid = 1'b1; req_load = ld; req_store = st; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        #1 stall0 = stall;
        dcyc = -1; nrd = 0; nwr = 0; wdat = 32'd0; ldat = 32'd0; mis = 1'b0; af = 1'b0;
        for (int c = 1; c <= 8 && dcyc < 0; c++) begin
            @(negedge clock);
            req_addr  = 32'h0000_0FF0;
            req_wdata = ~wd;
            if (memread) nrd++;
            if (memwrite) begin nwr++; wdat = write_d; end
            if (done) begin dcyc = c; ldat = load_data; mis = misalign; af = addr_fault; end
        end
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    endtask

    int          dc, nr, nw;
    logic [31:0] wdv, ldv;
    logic        mf, af, st0;
    int          late_wr, late_done;

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;

        // Reset and idle outputs
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_memread",  32'(memread),  32'd0);
        chk("rst_memwrite", 32'(memwrite), 32'd0);
        chk("rst_stall",    32'(stall),    32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_mem_addr", mem_addr,      32'd0);
        chk("rst_load_data", load_data,    32'd0);

        // Valid without load/store does nothing
        @(negedge clock);
        req_valid = 1'b1;
        #1 chk("noop_stall", 32'(stall), 32'd0);
        @(negedge clock);
        chk("noop_memread", 32'(memread), 32'd0);
        chk("noop_done",    32'(done),    32'd0);
        req_valid = 1'b0;

        // Word store then word load at 0
        run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h1111_1111, dc, nr, nw, wdv, ldv, mf, af, st0);
        chk("sw_stall0", 32'(st0), 32'd1);
        chk("sw_done_cyc", 32'(dc), 32'd2);
        chk("sw_nwr", 32'(nw), 32'd1);
        chk("sw_nrd", 32'(nr), 32'd0);
        chk("sw_wdata", wdv, 32'h1111_1111);
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, dc, nr, nw, wdv, ldv, mf, af, st0);
        chk("lw_done_cyc", 32'(dc), 32'd3);
        chk("lw_nrd", 32'(nr), 32'd1);
        chk("lw_nwr", 32'(nw), 32'd0);
        chk("lw_data", ldv, 32'h1111_1111);

        // Preload words through the unit
        run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h1234_5678, dc, nr, nw, wdv, ldv, mf, af, st0);
        chk("pre100_done_cyc", 32'(dc), 32'd2);
        run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF_7F01, dc, nr, nw, wdv, ldv, mf, af, st0);
        chk("pre10_done_cyc", 32'(dc), 32'd2);
        run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h104, 32'hCAFE_F00D, dc, nr, nw, wdv, ldv, mf, af, st0);
        chk("pre104_done_cyc", 32'(dc), 32'd2);

        // Sub-word stores via read-modify-write
        run_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_00AB, dc, nr, nw, wdv, ldv, mf, af, st0);
        chk("sb_done_cyc", 32'(dc), 32'd4);
        chk("sb_nrd", 32'(nr), 32'd1);
        chk("sb_nwr", 32'(nw), 32'd1);
        chk("sb_wdata", wdv, 32'h12AB_5678);
        run_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_BEEF, dc, nr, nw, wdv, ldv, mf, af, st0);
        chk("sh_done_cyc", 32'(dc), 32'd4);
        chk("sh_wdata", wdv, 32'h12AB_BEEF);
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, dc, nr, nw, wdv, ldv, mf, af, st0);
        chk("sh_readback", ldv, 32'h12AB_BEEF);

        // Load extension, load wins when both load and store are set
        run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, dc, nr, nw, wdv, ldv, mf, af, st0);
        chk("lb_data", ldv, 32'hFFFF_FF80);
        chk("lb_done_cyc", 32'(dc), 32'd3);
        run_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, dc, nr, nw, wdv, ldv, mf, af, st0);
        chk("lbu_data", ldv, 32'h0000_0080);
        run_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, dc, nr, nw, wdv, ldv, mf, af, st0);
        chk("lh_data", ldv, 32'h0000_7F01);
        run_op(1'b1, 1'b1, 2'b01, 1'b1, 32'h10, 32'h0, dc, nr, nw, wdv, ldv, mf, af, st0);
        chk("lhu_both_data", ldv, 32'h0000_80FF);
        chk("lhu_both_nwr", 32'(nw), 32'd0);
        run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, dc, nr, nw, wdv, ldv, mf, af, st0);
        chk("lb3_data", ldv, 32'h0000_0001);

        // Faults
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, dc, nr, nw, wdv, ldv, mf, af, st0);
        chk("lw_mis_done_cyc", 32'(dc), 32'd1);
        chk("lw_mis_flag", 32'(mf), 32'd1);
        chk("lw_mis_af", 32'(af), 32'd0);
        chk("lw_mis_mem", 32'(nr + nw), 32'd0);
        chk("lw_mis_ldata", ldv, 32'd0);
        run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h3000, 32'h5, dc, nr, nw, wdv, ldv, mf, af, st0);
        chk("sw_af_done_cyc", 32'(dc), 32'd1);
        chk("sw_af_flag", 32'(af), 32'd1);
        chk("sw_af_mis", 32'(mf), 32'd0);
        chk("sw_af_mem", 32'(nr + nw), 32'd0);
        run_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h3001, 32'h5, dc, nr, nw, wdv, ldv, mf, af, st0);
        chk("sh_both_flags", {30'd0, mf, af}, 32'd3);
        chk("sh_both_mem", 32'(nr + nw), 32'd0);
        run_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, dc, nr, nw, wdv, ldv, mf, af, st0);
        chk("size11_mis", 32'(mf), 32'd1);
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h2FFC, 32'h0, dc, nr, nw, wdv, ldv, mf, af, st0);
        chk("lw_top_nofault", {30'd0, mf, af}, 32'd0);
        chk("lw_top_done_cyc", 32'(dc), 32'd3);

        // Reset during CAP of a sub-word store abandons it
        late_wr = 0; late_done = 0;
        @(negedge clock);
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'b00; req_addr = 32'h104; req_wdata = 32'h55;
        @(negedge clock);
        if (memwrite) late_wr++;
        @(negedge clock);
        if (memwrite) late_wr++;
        reset = 1'b0; req_valid = 1'b0; req_store = 1'b0;
        @(negedge clock);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (memwrite) late_wr++;
            if (done) late_done++;
            @(negedge clock);
        end
        chk("midrst_nwr", 32'(late_wr), 32'd0);
        chk("midrst_ndone", 32'(late_done), 32'd0);
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, dc, nr, nw, wdv, ldv, mf, af, st0);
        chk("midrst_lw_done_cyc", 32'(dc), 32'd3);
        chk("midrst_lw_data", ldv, 32'hCAFE_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
